// File: rtl/word_frame_serializer.sv
// Word-to-byte frame serializer: SYNC byte, then tagged payload bytes, MSB chunk first.
// Define SER_CHECKSUM_EN to append an XOR checksum byte after the data bytes.
module word_frame_serializer #(
    parameter int         DATA_W    = 16,
    parameter int         PAY_W     = 6,
    parameter logic [7:0] SYNC_BYTE = 8'h3F
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] din_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    output logic [7:0]        out_data_o,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic              frame_done_o
);

    localparam int TAG_W = 8 - PAY_W;
    localparam int NB    = (DATA_W + PAY_W - 1) / PAY_W;
    localparam int REM   = DATA_W - (NB - 1) * PAY_W;

    if (NB > (2 ** TAG_W) - 1) begin : g_bad_cfg
        $fatal(1, "word_frame_serializer: NB does not fit in the tag field");
    end

`ifdef SER_CHECKSUM_EN
    typedef enum logic [1:0] {IDLE, SYNC, DATA, CSUM} state_e;
`else
    typedef enum logic [1:0] {IDLE, SYNC, DATA} state_e;
`endif

    state_e             state_q, state_d;
    logic [TAG_W-1:0]   idx_q, idx_d;
    logic [DATA_W-1:0]  word_q, word_d;
    logic [7:0]         data_q, data_d;
    logic               valid_q, valid_d;
    logic               ready_q, ready_d;
    logic               done_q, done_d;
    logic               hs;
`ifdef SER_CHECKSUM_EN
    logic [7:0]         csum_q, csum_d;
`endif

    // Chunk 1 holds the leftover top bits, left-aligned; the rest are PAY_W-aligned.
    function automatic logic [7:0] frame_byte(
        input logic [DATA_W-1:0] w,
        input logic [TAG_W-1:0]  k
    );
        logic [PAY_W-1:0] pay;
        int               sh;
        sh  = (NB - int'(k)) * PAY_W;
        pay = PAY_W'(w >> sh);
        if (k == TAG_W'(1)) pay = pay << (PAY_W - REM);
        return {k, pay};
    endfunction

    assign hs = valid_q && out_ready_i;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        word_d  = word_q;
        data_d  = data_q;
        valid_d = valid_q;
        ready_d = ready_q;
        done_d  = 1'b0;
`ifdef SER_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (in_valid_i) begin
                    word_d  = din_i;
                    state_d = SYNC;
                    idx_d   = '0;
                    data_d  = SYNC_BYTE;
                    valid_d = 1'b1;
                    ready_d = 1'b0;
`ifdef SER_CHECKSUM_EN
                    csum_d  = '0;
`endif
                end
            end
            SYNC: begin
                if (hs) begin
                    state_d = DATA;
                    idx_d   = TAG_W'(1);
                    data_d  = frame_byte(word_q, TAG_W'(1));
                end
            end
            DATA: begin
                if (hs) begin
                    if (idx_q == TAG_W'(NB)) begin
`ifdef SER_CHECKSUM_EN
                        state_d = CSUM;
                        data_d  = csum_q ^ data_q;
`else
                        state_d = IDLE;
                        idx_d   = '0;
                        valid_d = 1'b0;
                        ready_d = 1'b1;
                        done_d  = 1'b1;
`endif
                    end else begin
                        idx_d  = idx_q + TAG_W'(1);
                        data_d = frame_byte(word_q, idx_q + TAG_W'(1));
                    end
`ifdef SER_CHECKSUM_EN
                    csum_d = csum_q ^ data_q;
`endif
                end
            end
`ifdef SER_CHECKSUM_EN
            CSUM: begin
                if (hs) begin
                    state_d = IDLE;
                    idx_d   = '0;
                    valid_d = 1'b0;
                    ready_d = 1'b1;
                    done_d  = 1'b1;
                end
            end
`endif
            default: begin
                state_d = IDLE;
                idx_d   = '0;
                valid_d = 1'b0;
                ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            word_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
`ifdef SER_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ready_q <= ready_d;
            done_q  <= done_d;
`ifdef SER_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    assign in_ready_o   = ready_q;
    assign out_data_o   = data_q;
    assign out_valid_o  = valid_q;
    assign frame_done_o = done_q;

endmodule
